switch_debounce: RTL and testbench

- Input-side conditioner for the board's slide switches and push buttons.
- Takes raw, asynchronous, bouncy switch pins and produces clean, synchronous levels plus single-cycle edge pulses.
- Its outputs drive the gate/LED logic inputs (in_a, in_b, in_c).
- One independent debounce channel per input bit.

---
 rtl/switch_debounce_pkg.sv | 20 ++
 rtl/debounce_chan.sv | 140 ++++++++++++++
 rtl/switch_debounce.sv | 48 ++++
 tb/tb_switch_debounce.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/switch_debounce_pkg.sv
// Shared types and constants for the switch debounce block.
// Optional feature macro: SWITCH_DEBOUNCE_TOGGLE_EN (see debounce_chan).
package switch_debounce_pkg;

    // Per-channel debounce state.
    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        CHK_HI  = 2'd1,
        IDLE_HI = 2'd2,
        CHK_LO  = 2'd3
    } chan_state_t;

    // 10 ms at 50 MHz.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int DEFAULT_CNT_W           = 20;

    // Short window so simulations stay fast.
    localparam int SIM_DEBOUNCE_CYCLES     = 4;

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: 2-flop synchronizer, stability counter, FSM, edge pulses.
// With SWITCH_DEBOUNCE_TOGGLE_EN defined, o_level toggles on each accepted rise.
module debounce_chan
    import switch_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_change_nxt
);

    localparam logic [CNT_W-1:0] LP_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LP_ZERO = '0;

    logic             r_sync1;
    logic             r_sync2;
    chan_state_t      r_state;
    chan_state_t      w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_acc_rise;
    logic             w_acc_fall;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;

    // Two-flop synchronizer; nothing else looks at i_raw.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE_LO;
            r_cnt   <= LP_ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: count consecutive differing samples, drop back on a bounce.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            IDLE_LO: begin
                if (r_sync2) begin
                    w_state_nxt = CHK_HI;
                    w_cnt_nxt   = LP_ONE;
                end else begin
                    w_cnt_nxt   = LP_ZERO;
                end
            end
            CHK_HI: begin
                if (!r_sync2) begin
                    w_state_nxt = IDLE_LO;
                    w_cnt_nxt   = LP_ZERO;
                end else if (r_cnt == LP_MAX) begin
                    w_state_nxt = IDLE_HI;
                    w_cnt_nxt   = LP_ZERO;
                end else begin
                    w_cnt_nxt   = r_cnt + LP_ONE;
                end
            end
            IDLE_HI: begin
                if (!r_sync2) begin
                    w_state_nxt = CHK_LO;
                    w_cnt_nxt   = LP_ONE;
                end else begin
                    w_cnt_nxt   = LP_ZERO;
                end
            end
            CHK_LO: begin
                if (r_sync2) begin
                    w_state_nxt = IDLE_HI;
                    w_cnt_nxt   = LP_ZERO;
                end else if (r_cnt == LP_MAX) begin
                    w_state_nxt = IDLE_LO;
                    w_cnt_nxt   = LP_ZERO;
                end else begin
                    w_cnt_nxt   = r_cnt + LP_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE_LO;
                w_cnt_nxt   = LP_ZERO;
            end
        endcase
    end

    // Acceptance strobes decoded from the current state and sample.
    always_comb begin
        w_acc_rise = (r_state == CHK_HI) && r_sync2 && (r_cnt == LP_MAX);
        w_acc_fall = (r_state == CHK_LO) && !r_sync2 && (r_cnt == LP_MAX);
    end

    // Registered level and one-cycle edge pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= w_acc_rise;
            r_fall <= w_acc_fall;
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
            if (w_acc_rise) begin
                r_level <= ~r_level;
            end
`else
            if (w_acc_rise) begin
                r_level <= 1'b1;
            end else if (w_acc_fall) begin
                r_level <= 1'b0;
            end
`endif
        end
    end

    assign o_level      = r_level;
    assign o_rise       = r_rise;
    assign o_fall       = r_fall;
    assign o_change_nxt = w_acc_rise | w_acc_fall;

endmodule

// File: rtl/switch_debounce.sv
// Debounces N_IN raw switch pins into clean levels and edge pulses.
// Optional macro SWITCH_DEBOUNCE_TOGGLE_EN turns each level into a toggle.
module switch_debounce
    import switch_debounce_pkg::*;
#(
    parameter int N_IN            = 3,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_IN-1:0] sw_raw,
    output logic [N_IN-1:0] sw_level,
    output logic [N_IN-1:0] sw_rise,
    output logic [N_IN-1:0] sw_fall,
    output logic            sw_any_change
);

    logic [N_IN-1:0] w_change_nxt;
    logic            r_any_change;

    for (genvar g = 0; g < N_IN; g++) begin : g_chan
        debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .i_raw        (sw_raw[g]),
            .o_level      (sw_level[g]),
            .o_rise       (sw_rise[g]),
            .o_fall       (sw_fall[g]),
            .o_change_nxt (w_change_nxt[g])
        );
    end

    // Registered from the pre-register strobes so it lines up with the pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_any_change <= 1'b0;
        end else begin
            r_any_change <= |w_change_nxt;
        end
    end

    assign sw_any_change = r_any_change;

endmodule

// File: tb/tb_switch_debounce.sv
// Table-driven bench for switch_debounce with a scoreboard queue.
// Define SWITCH_DEBOUNCE_TOGGLE_EN to check the toggle build.
module tb_switch_debounce;
    import switch_debounce_pkg::*;

    localparam int N = 3;
    localparam int D = SIM_DEBOUNCE_CYCLES;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] sw_raw = '0;
    logic [N-1:0] sw_level;
    logic [N-1:0] sw_rise;
    logic [N-1:0] sw_fall;
    logic         sw_any_change;

    switch_debounce #(
        .N_IN            (N),
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sw_raw        (sw_raw),
        .sw_level      (sw_level),
        .sw_rise       (sw_rise),
        .sw_fall       (sw_fall),
        .sw_any_change (sw_any_change)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic [N-1:0] raw;
        logic [N-1:0] lvl;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
    } vec_t;

    typedef struct packed {
        logic [N-1:0] lvl;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
        logic         any;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    logic [N-1:0] tog;

    task automatic add(input logic r, input logic [N-1:0] raw,
                       input logic [N-1:0] lvl, input logic [N-1:0] rise,
                       input logic [N-1:0] fall);
        vec_t v;
        v.rst  = r;
        v.raw  = raw;
        v.lvl  = lvl;
        v.rise = rise;
        v.fall = fall;
        vecs.push_back(v);
    endtask

    // Hold raw for n edges starting from debounced level old.
    // New level appears after edge D+2 counted from the sampling edge (0).
    task automatic step(input logic [N-1:0] raw, input logic [N-1:0] old,
                        input int n);
        for (int k = 0; k < n; k++) begin
            if (k < D + 2)
                add(1'b0, raw, old, '0, '0);
            else if (k == D + 2)
                add(1'b0, raw, raw, raw & ~old, old & ~raw);
            else
                add(1'b0, raw, raw, '0, '0);
        end
    endtask

    task automatic check(input string name, input exp_t e);
        exp_t got;
        got = {sw_level, sw_rise, sw_fall, sw_any_change};
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s: got lvl=%b rise=%b fall=%b any=%b, want lvl=%b rise=%b fall=%b any=%b",
                     name, got.lvl, got.rise, got.fall, got.any,
                     e.lvl, e.rise, e.fall, e.any);
        end
    endtask

    initial begin
        logic [6:0] bounce;
        exp_t       e;
        exp_t       p;

        // Reset held with all switches high, then release.
        for (int i = 0; i < 3; i++) add(1'b1, 3'b111, '0, '0, '0);
        step(3'b111, 3'b000, 9);
        step(3'b000, 3'b111, 9);
        // Single channel rise and fall.
        step(3'b001, 3'b000, 9);
        step(3'b000, 3'b001, 9);
        // Bounce on channel 1: 1,1,0,1,1,1,0 then low.
        bounce = 7'b1101110;
        for (int i = 6; i >= 0; i--)
            add(1'b0, {1'b0, bounce[i], 1'b0}, '0, '0, '0);
        for (int i = 0; i < 8; i++) add(1'b0, 3'b000, '0, '0, '0);
        // Channel 2 rises, reset pulse interrupts, then restarts.
        for (int i = 0; i < 3; i++) add(1'b0, 3'b100, '0, '0, '0);
        add(1'b1, 3'b100, '0, '0, '0);
        step(3'b100, 3'b000, 9);
        step(3'b000, 3'b100, 9);
        // Three clean press/release cycles on channel 1.
        for (int i = 0; i < 3; i++) begin
            step(3'b010, 3'b000, 9);
            step(3'b000, 3'b010, 9);
        end
        // Simultaneous rise on channels 0 and 2.
        step(3'b101, 3'b000, 9);

        tog = '0;
        foreach (vecs[i]) begin
            @(negedge clk);
            rst    = vecs[i].rst;
            sw_raw = vecs[i].raw;
            if (vecs[i].rst) tog = '0;
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
            tog   = tog ^ vecs[i].rise;
            e.lvl = tog;
`else
            e.lvl = vecs[i].lvl;
`endif
            e.rise = vecs[i].rise;
            e.fall = vecs[i].fall;
            e.any  = |(vecs[i].rise | vecs[i].fall);
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            p = exp_q.pop_front();
            check($sformatf("vec%0d", i), p);
        end

        // Asynchronous reset: outputs drop without a clock edge.
        @(negedge clk);
        #2;
        rst = 1'b1;
        exp_q.push_back('0);
        #1;
        p = exp_q.pop_front();
        check("async_rst", p);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
